// File: rtl/pipeline_hazard_control_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_control_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               controller.
//               slave  modport : used by the hazard controller
//                 in  : IdRs1, IdRs2, IdUsesRs1, IdUsesRs2, ExRd, ExMemRead,
//                       ExBranchTaken, ExMulStart
//                 out : PcEnable, IfIdEnable, IdExEnable, IfIdFlush,
//                       IdExFlush, ExMemBubble, MulResultValid, StallCount
//               master modport : used by the datapath or testbench, with
//                 every direction reversed.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_control_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           IdRs1;
    logic [4:0]           IdRs2;
    logic                 IdUsesRs1;
    logic                 IdUsesRs2;
    logic [4:0]           ExRd;
    logic                 ExMemRead;
    logic                 ExBranchTaken;
    logic                 ExMulStart;
    logic                 PcEnable;
    logic                 IfIdEnable;
    logic                 IdExEnable;
    logic                 IfIdFlush;
    logic                 IdExFlush;
    logic                 ExMemBubble;
    logic                 MulResultValid;
    logic [CNT_WIDTH-1:0] StallCount;

    modport slave (
        input  IdRs1, IdRs2, IdUsesRs1, IdUsesRs2, ExRd, ExMemRead,
               ExBranchTaken, ExMulStart,
        output PcEnable, IfIdEnable, IdExEnable, IfIdFlush, IdExFlush,
               ExMemBubble, MulResultValid, StallCount
    );

    modport master (
        output IdRs1, IdRs2, IdUsesRs1, IdUsesRs2, ExRd, ExMemRead,
               ExBranchTaken, ExMulStart,
        input  PcEnable, IfIdEnable, IdExEnable, IfIdFlush, IdExFlush,
               ExMemBubble, MulResultValid, StallCount
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_control
// Description : Hazard controller for a five-stage pipeline. It handles three
//               cases:
//                 - load-use stalls, which insert one bubble
//                 - taken-branch flushes
//                 - a multi-cycle EX-stage multiplier, which freezes the
//                   front end until the multiplier result is valid
// Ports       : CLK, Reset (asynchronous, active high)
//               bus - pipeline_hazard_control_if.slave
// Parameters  : MUL_LATENCY (2..15), CNT_WIDTH
// Option      : HAZARD_PERF_CNT_EN - when defined, StallCount counts the
//               cycles with PcEnable low and saturates at all-ones. When it is
//               undefined, StallCount is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_control #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic                 CLK,
    input  wire logic                 Reset,
    pipeline_hazard_control_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    // The start cycle and the result-valid cycle are both part of the
    // latency. That leaves MUL_LATENCY-2 cycles in MUL_BUSY.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 2);

    state_t     state, next_state;
    logic [3:0] mul_cnt, mul_cnt_next;
    logic       load_use;
    logic       pc_en, ifid_en, idex_en;
    logic       ifid_flush, idex_flush, exmem_bubble, mul_valid;

    assign load_use = bus.ExMemRead && (bus.ExRd != 5'd0) &&
                      ((bus.IdUsesRs1 && (bus.IdRs1 == bus.ExRd)) ||
                       (bus.IdUsesRs2 && (bus.IdRs2 == bus.ExRd)));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
        end else begin
            state   <= next_state;
            mul_cnt <= mul_cnt_next;
        end
    end

    always_comb begin
        next_state   = state;
        mul_cnt_next = mul_cnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        mul_valid    = 1'b0;

        case (state)
            RUN: begin
                if (bus.ExMulStart) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_bubble = 1'b1;
                    mul_cnt_next = MUL_LOAD;
                    // When MUL_LATENCY is 2 there are no busy cycles, so the
                    // next cycle must already present the result.
                    next_state   = (MUL_LOAD == 4'd0) ? MUL_DONE : MUL_BUSY;
                end else if (bus.ExBranchTaken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MUL_BUSY: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_bubble = 1'b1;
                mul_cnt_next = mul_cnt - 4'd1;
                // Leave once the decremented count reaches zero. The
                // remaining busy cycles then equal the loaded value.
                if (mul_cnt <= 4'd1) begin
                    mul_cnt_next = 4'd0;
                    next_state   = MUL_DONE;
                end
            end
            MUL_DONE: begin
                mul_valid  = 1'b1;
                next_state = RUN;
                if (bus.ExBranchTaken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase

        // While reset is held, the pipeline is frozen with no side effects.
        if (Reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            mul_valid    = 1'b0;
        end
    end

    assign bus.PcEnable       = pc_en;
    assign bus.IfIdEnable     = ifid_en;
    assign bus.IdExEnable     = idex_en;
    assign bus.IfIdFlush      = ifid_flush;
    assign bus.IdExFlush      = idex_flush;
    assign bus.ExMemBubble    = exmem_bubble;
    assign bus.MulResultValid = mul_valid;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (!pc_en && (stall_count != {CNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.StallCount = stall_count;
`else
    assign bus.StallCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_control
// Description : Directed self-checking bench for pipeline_hazard_control,
//               using the default parameters (MUL_LATENCY=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_control;
    logic CLK;
    logic Reset;
    int   tests_run;
    int   tests_failed;

    pipeline_hazard_control_if #(.CNT_WIDTH(16)) bus ();

    pipeline_hazard_control #(
        .MUL_LATENCY (4),
        .CNT_WIDTH   (16)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks {PcEnable,IfIdEnable,IdExEnable} and
    // {IfIdFlush,IdExFlush,ExMemBubble,MulResultValid}.
    task automatic check_outs(input string tag, input logic [2:0] en, input logic [3:0] fl);
        check({tag, ".en"}, {29'd0, bus.PcEnable, bus.IfIdEnable, bus.IdExEnable}, {29'd0, en});
        check({tag, ".fl"}, {28'd0, bus.IfIdFlush, bus.IdExFlush, bus.ExMemBubble,
                             bus.MulResultValid}, {28'd0, fl});
    endtask

    task automatic clear_inputs();
        bus.IdRs1 = 5'd0; bus.IdRs2 = 5'd0;
        bus.IdUsesRs1 = 1'b0; bus.IdUsesRs2 = 1'b0;
        bus.ExRd = 5'd0; bus.ExMemRead = 1'b0;
        bus.ExBranchTaken = 1'b0; bus.ExMulStart = 1'b0;
    endtask

    // Inputs change 1 time unit after the clock edge, and outputs are checked
    // 1 time unit after that, well away from the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.IdRs1 = 5'd5; bus.IdUsesRs1 = 1'b1;
        bus.ExRd = rd;    bus.ExMemRead = 1'b1;
    endtask

    logic [15:0] exp_cnt;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef HAZARD_PERF_CNT_EN
        exp_cnt = 16'd4;
`else
        exp_cnt = 16'd0;
`endif
        clear_inputs();
        Reset = 1'b1;
        tick();
        #1;
        check_outs("reset", 3'b000, 4'b0000);
        check("reset.cnt", {16'd0, bus.StallCount}, 32'd0);
        Reset = 1'b0;
        tick();

        // Idle RUN
        #1 check_outs("idle", 3'b111, 4'b0000);

        // Load-use hazard on Rs1: exactly one stall cycle
        set_load_use(5'd5);
        #1 check_outs("lu.stall", 3'b001, 4'b0100);
        tick();
        clear_inputs();
        #1 check_outs("lu.after", 3'b111, 4'b0000);

        // Register x0 never produces a hazard
        set_load_use(5'd0);
        #1 check_outs("lu.x0", 3'b111, 4'b0000);

        // A taken branch overrides the load-use hazard
        set_load_use(5'd5);
        bus.ExBranchTaken = 1'b1;
        #1 check_outs("br.lu", 3'b111, 4'b1100);
        tick();
        clear_inputs();

        // Multiply started together with a branch and a hazard: the multiply wins
        set_load_use(5'd5);
        bus.ExBranchTaken = 1'b1;
        bus.ExMulStart = 1'b1;
        #1 check_outs("mul.c0", 3'b000, 4'b0010);
        tick();
        clear_inputs();
        bus.ExBranchTaken = 1'b1;
        #1 check_outs("mul.c1", 3'b000, 4'b0010);
        tick();
        clear_inputs();
        #1 check_outs("mul.c2", 3'b000, 4'b0010);
        tick();
        #1 check_outs("mul.c3", 3'b111, 4'b0001);
        tick();
        #1 check_outs("mul.c4", 3'b111, 4'b0000);
        check("stallcnt", {16'd0, bus.StallCount}, {16'd0, exp_cnt});

        // Hazard on Rs2; the hazard needs IdUsesRs2 to be set
        bus.IdRs1 = 5'd3; bus.IdRs2 = 5'd7; bus.IdUsesRs1 = 1'b1;
        bus.IdUsesRs2 = 1'b1; bus.ExRd = 5'd7; bus.ExMemRead = 1'b1;
        #1 check_outs("rs2.stall", 3'b001, 4'b0100);
        bus.IdUsesRs2 = 1'b0;
        #1 check_outs("rs2.unused", 3'b111, 4'b0000);
        bus.IdUsesRs2 = 1'b1; bus.ExMemRead = 1'b0;
        #1 check_outs("rs2.noload", 3'b111, 4'b0000);
        clear_inputs();
        tick();

        // Load-use hazard during the MUL_DONE cycle is still honoured
        bus.ExMulStart = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        set_load_use(5'd5);
        bus.ExMulStart = 1'b1;
        #1 check_outs("done.lu", 3'b001, 4'b0101);
        tick();
        clear_inputs();
        #1 check_outs("done.next", 3'b111, 4'b0000);

        // Reset asserted in multiply cycle 1 aborts the multiply
        bus.ExMulStart = 1'b1;
        tick();
        clear_inputs();
        #1 check_outs("rst.busy", 3'b000, 4'b0010);
        #2 Reset = 1'b1;
        #1 check_outs("rst.async", 3'b000, 4'b0000);
        check("rst.cnt", {16'd0, bus.StallCount}, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check_outs("rst.after", 3'b111, 4'b0000);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
